fetch: RTL
==========

# fetch

Instruction fetch stage: the producing end of the fetch-to-decode link. It issues pipelined word reads to instruction memory and buffers the returned words in a prefetch queue. Each cycle it presents one instruction, or a never-execute bubble, to decode. It honours decode's hold and redirects when decode flags a PC-changing instruction or writeback loads a new PC.

## Interface
Parameters:
- DEPTH, 4: prefetch queue entries and maximum outstanding reads; power of two, ≥2.
- RESET_PC, 32'h0: first fetch address after reset.

Ports:
- clock  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- imem_address  out  32  byte address of read request, word aligned.
- imem_read  out  1  read request.
- imem_waitrequest  in  1  memory not accepting; request and address held.
- imem_readdata  in  32  returned instruction word.
- imem_readdatavalid  in  1  readdata valid; responses return in order.
- pc_load  in  1  writeback has written PC; redirect.
- pc_value  in  32  new PC; valid with pc_load.
- pc_out  out  32  address of the instruction currently on outi.instruction.
- outi  i_fetch_to_decode.fetch_out  interface:
  - drives instruction (32).
  - samples hold and is_pc_changing.

## Operation
- Bubble is 32'h8000_0000: non-zero-active set, mask 0, so it never executes.
- State RUN:
  - Issue a read when free = DEPTH − (queue_count + outstanding) > 0.
  - A read is accepted when imem_read && !imem_waitrequest.
  - On acceptance, fetch_pc += 4 and outstanding++.
- Response handling:
  - Each imem_readdatavalid decrements outstanding.
  - If stale > 0: discard the data and decrement stale.
  - Otherwise push {data, address} into the queue.
- Presentation:
  - instruction = queue head in RUN with a non-empty queue; otherwise bubble.
  - pc_out = head address, or fetch_pc when the queue is empty.
  - The head is popped at the edge where !outi.hold and the queue is non-empty.
- Redirect on outi.is_pc_changing:
  - Sampled only when !outi.hold.
  - Clear the queue; stale = outstanding (including any request accepted that edge).
  - State becomes WAIT.
- State WAIT:
  - No new requests are issued.
  - A request already asserted under waitrequest stays asserted with the same address until accepted; it is then counted stale.
  - Bubble is presented.
- pc_load, any state:
  - Clear the queue; stale = outstanding; fetch_pc = pc_value.
  - State becomes RUN unless is_pc_changing is sampled the same edge; then state becomes WAIT with fetch_pc already loaded.
- Hold:
  - Freezes instruction and pc_out.
  - Fetch and response capture continue while queue space remains.
- Queue full while responses arrive: impossible by the free-slot rule; the bench asserts it never happens.

## Timing
- Reset values:
  - imem_read 0, imem_address RESET_PC.
  - instruction bubble, pc_out RESET_PC.
  - State RUN; queue empty; outstanding 0; stale 0.
- First imem_read rises in the first cycle after reset deasserts.
- Latency: readdatavalid at edge N → instruction on outi from cycle N+1; no bypass.
- Redirect: instruction is bubble in the cycle after is_pc_changing is sampled. New-PC request is issued in the cycle after pc_load, when imem_read is free.
- Reset mid-transaction drops all state. Late responses after reset are not expected and are ignored only if stale > 0.

## Configuration
- FETCH_PREFETCH_EN defined: up to DEPTH outstanding reads; back-to-back issue.
- FETCH_PREFETCH_EN undefined:
  - At most one outstanding read, and the queue holds one entry.
  - A read issues only when the queue is empty or being popped that edge.
  - Throughput is one instruction per memory round trip.

## Structure
- Shared package:
  - BUBBLE_INSTRUCTION constant.
  - fetch_state_t enum {RUN, WAIT}.
  - regval_t for addresses and data.
- Sub-module fetch_queue: synchronous FIFO of {regval_t data, regval_t address}.
  - Ports: push, pop, clear (priority over push), head, count.
  - Pointers wrap modulo DEPTH.

## Test plan
- Reset, zero-wait memory returning address as data, hold 0 → reads at 0,4,8…; instruction 0,4,8 consecutive from cycle 3; pc_out tracks.
- Hold for 5 cycles with DEPTH=4 → queue fills to 4; imem_read drops; instruction frozen; after release, no word is skipped or duplicated.
- is_pc_changing with 3 reads outstanding → bubble next cycle; 3 responses discarded; no reads. pc_load to 32'h100 → next read at 32'h100; first presented instruction is 32'h100.
- is_pc_changing while imem_waitrequest held 4 cycles → read held at the same address until accepted; its response discarded.
- pc_load and is_pc_changing at the same edge → state WAIT, no reads. Second pc_load 32'h200 → fetch resumes at 32'h200.
- FETCH_PREFETCH_EN undefined, 3-cycle read latency → never more than 1 outstanding; one instruction per 4 cycles.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;
  typedef logic [31:0] regval_t;

  // Non-zero-active set with an empty mask: decode never executes it.
  localparam regval_t BUBBLE_INSTRUCTION = 32'h8000_0000;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} fetch_state_t;

  typedef struct packed {
    regval_t data;
    regval_t address;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch-to-decode link carrying instruction, hold and redirect
interface i_fetch_to_decode;
  import fetch_pkg::*;

  regval_t instruction;
  logic    hold;
  logic    is_pc_changing;

  modport fetch_out (output instruction, input hold, input is_pc_changing);
  modport decode_in (input instruction, output hold, output is_pc_changing);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {data, address} with synchronous clear
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  fetch_entry_t           i_entry,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Clear wins over push so a redirect never keeps a word from the old stream.
  assign w_do_push = i_push && !i_clear;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_clear;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Entry storage; contents are only meaningful below r_count so no reset.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // Pointers wrap naturally modulo the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end
endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage; FETCH_PREFETCH_EN enables multi-outstanding prefetch
module fetch
  import fetch_pkg::*;
#(
  parameter int      DEPTH    = 4,
  parameter regval_t RESET_PC = 32'h0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output regval_t                    imem_address,
  output logic                       imem_read,
  input  logic                       imem_waitrequest,
  input  regval_t                    imem_readdata,
  input  logic                       imem_readdatavalid,
  input  logic                       pc_load,
  input  regval_t                    pc_value,
  output regval_t                    pc_out,
  i_fetch_to_decode.fetch_out        outi
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t   r_state;
  regval_t        r_fetch_pc;
  regval_t        r_resp_pc;
  regval_t        r_held_address;
  logic [CW-1:0]  r_outstanding;
  logic [CW-1:0]  r_stale;
  logic           r_enable;
  logic           r_held;
  logic           r_held_stale;

  fetch_entry_t   w_head;
  fetch_entry_t   w_entry;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_outstanding_next;
  logic           w_accept;
  logic           w_accept_stale;
  logic           w_pop;
  logic           w_push;
  logic           w_discard;
  logic           w_redirect;
  logic           w_flush;
  logic           w_room;

  assign w_pop      = !outi.hold && (w_count != '0);
  assign w_redirect = !outi.hold && outi.is_pc_changing;
  assign w_flush    = w_redirect || pc_load;
  assign w_discard  = imem_readdatavalid && (r_stale != '0);
  assign w_push     = imem_readdatavalid && (r_stale == '0);
  assign w_entry    = '{data: imem_readdata, address: r_resp_pc};

`ifdef FETCH_PREFETCH_EN
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  // Every queued word and every read in flight holds one slot.
  assign w_room = (w_count + r_outstanding) < CAP;
`else
  // Single-slot mode: one read in flight, issued once the slot is (being) freed.
  assign w_room = ((w_count == '0) || w_pop) && (r_outstanding == '0);
`endif

  // A request stalled by waitrequest keeps its address even across redirects.
  assign imem_read      = r_held || (r_enable && (r_state == RUN) && w_room);
  assign imem_address   = r_held ? r_held_address : r_fetch_pc;
  assign w_accept       = imem_read && !imem_waitrequest;
  assign w_accept_stale = w_accept && r_held && r_held_stale;
  assign w_outstanding_next = r_outstanding + {{(CW-1){1'b0}}, w_accept}
                            - {{(CW-1){1'b0}}, imem_readdatavalid};

  assign outi.instruction = ((r_state == RUN) && (w_count != '0)) ? w_head.data
                                                                  : BUBBLE_INSTRUCTION;
  assign pc_out = (w_count != '0) ? w_head.address : r_fetch_pc;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_clear (w_flush),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Run/wait state, pc tracking and outstanding/stale read accounting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= RUN;
      r_fetch_pc     <= RESET_PC;
      r_resp_pc      <= RESET_PC;
      r_held_address <= RESET_PC;
      r_outstanding  <= '0;
      r_stale        <= '0;
      r_enable       <= 1'b0;
      r_held         <= 1'b0;
      r_held_stale   <= 1'b0;
    end else begin
      r_enable       <= 1'b1;
      r_outstanding  <= w_outstanding_next;
      r_held         <= imem_read && imem_waitrequest;
      r_held_address <= imem_address;
      r_held_stale   <= imem_read && imem_waitrequest &&
                        (w_flush || (r_held && r_held_stale));

      // Everything in flight at a redirect belongs to the abandoned stream.
      if (w_flush) r_stale <= w_outstanding_next;
      else r_stale <= r_stale - {{(CW-1){1'b0}}, w_discard}
                              + {{(CW-1){1'b0}}, w_accept_stale};

      if (pc_load) r_fetch_pc <= pc_value;
      else if (w_accept && !w_accept_stale) r_fetch_pc <= r_fetch_pc + 32'd4;

      // Responses return in order, so the next kept word's address is implied.
      if (pc_load) r_resp_pc <= pc_value;
      else if (w_push) r_resp_pc <= r_resp_pc + 32'd4;

      if (pc_load) r_state <= w_redirect ? WAIT : RUN;
      else if (w_redirect) r_state <= WAIT;
    end
  end
endmodule
